// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit
// Purpose  : PC register plus instruction fetch/hold FSM feeding the control unit.
//            Optional misaligned-target trap enabled by macro IFU_ALIGN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
    parameter int                  PC_BITS      = 64,
    parameter logic [PC_BITS-1:0]  RESET_VECTOR = '0,
    parameter logic [31:0]         INSTR_RESET  = 32'h0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               pc_load,
    input  logic [1:0]         pc_sel,
    input  logic [PC_BITS-1:0] K,
    input  logic [PC_BITS-1:0] reg_data,
    output logic [PC_BITS-1:0] imem_addr,
    output logic               imem_req,
    input  logic               imem_ready,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        instruction,
    output logic               instr_valid,
    output logic [PC_BITS-1:0] pc,
    output logic [PC_BITS-1:0] pc_plus4,
    output logic               fetch_fault
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1
`ifdef IFU_ALIGN_CHECK_EN
        , ST_FAULT = 2'd2
`endif
    } state_t;

    localparam logic [PC_BITS-1:0] c_align_mask = {{(PC_BITS-2){1'b1}}, 2'b00};

    state_t             r_state;
    state_t             w_state_next;
    logic [PC_BITS-1:0] r_pc;
    logic [31:0]        r_instruction;
    logic [PC_BITS-1:0] w_next_pc_raw;
    logic [PC_BITS-1:0] w_next_pc;
    logic               w_pc_update;
    logic               w_instr_load;
`ifdef IFU_ALIGN_CHECK_EN
    logic               r_fault;
    logic               w_fault_set;
`endif

    always_comb begin
        w_next_pc_raw = r_pc;
        case (pc_sel)
            2'b00:   w_next_pc_raw = r_pc + PC_BITS'(4);
            2'b01:   w_next_pc_raw = r_pc + (K << 2);
            2'b10:   w_next_pc_raw = reg_data;
            default: w_next_pc_raw = r_pc;
        endcase
    end

`ifdef IFU_ALIGN_CHECK_EN
    assign w_next_pc = w_next_pc_raw;
`else
    // Without the trap, low bits of a misaligned target are silently dropped
    assign w_next_pc = w_next_pc_raw & c_align_mask;
`endif

    always_comb begin
        w_state_next = r_state;
        w_pc_update  = 1'b0;
        w_instr_load = 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
        w_fault_set  = 1'b0;
`endif
        case (r_state)
            ST_FETCH: begin
                if (imem_ready) begin
                    w_instr_load = 1'b1;
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (pc_load) begin
`ifdef IFU_ALIGN_CHECK_EN
                    if (w_next_pc_raw[1:0] != 2'b00) begin
                        w_fault_set  = 1'b1;
                        w_state_next = ST_FAULT;
                    end else begin
                        w_pc_update  = 1'b1;
                        w_state_next = ST_FETCH;
                    end
`else
                    w_pc_update  = 1'b1;
                    w_state_next = ST_FETCH;
`endif
                end
            end
            default: w_state_next = r_state;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_FETCH;
            r_pc          <= RESET_VECTOR;
            r_instruction <= INSTR_RESET;
        end else begin
            r_state <= w_state_next;
            if (w_pc_update)
                r_pc <= w_next_pc;
            if (w_instr_load)
                r_instruction <= imem_rdata;
        end
    end

`ifdef IFU_ALIGN_CHECK_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_fault <= 1'b0;
        else if (w_fault_set)
            r_fault <= 1'b1;
    end
    assign fetch_fault = r_fault;
`else
    assign fetch_fault = 1'b0;
`endif

    assign imem_req    = (r_state == ST_FETCH);
    assign instr_valid = (r_state == ST_EXEC);
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign pc_plus4    = r_pc + PC_BITS'(4);
    assign instruction = r_instruction;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch_unit
// Purpose  : Directed plus randomized checks of instruction_fetch_unit against
//            a cycle-level reference model. Honours IFU_ALIGN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

    localparam logic [63:0] c_reset_vector = 64'h0;
    localparam logic [31:0] c_instr_reset  = 32'h0;

    logic        clock;
    logic        reset;
    logic        pc_load;
    logic [1:0]  pc_sel;
    logic [63:0] K;
    logic [63:0] reg_data;
    logic [63:0] imem_addr;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [63:0] pc;
    logic [63:0] pc_plus4;
    logic        fetch_fault;

    int tests = 0;
    int fails = 0;

    // Reference model: "have a word" / "faulted" flags rather than FSM states
    logic [63:0] m_pc;
    logic [31:0] m_instr;
    bit          m_valid;
    bit          m_fault;

    int          kk;
    logic [63:0] rgd;

    instruction_fetch_unit #(
        .PC_BITS      (64),
        .RESET_VECTOR (c_reset_vector),
        .INSTR_RESET  (c_instr_reset)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pc_load     (pc_load),
        .pc_sel      (pc_sel),
        .K           (K),
        .reg_data    (reg_data),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .fetch_fault (fetch_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = c_reset_vector;
        m_instr = c_instr_reset;
        m_valid = 0;
        m_fault = 0;
    endtask

    task automatic model_update();
        logic [63:0] t;
        if (!m_valid && !m_fault) begin
            if (imem_ready) begin
                m_instr = imem_rdata;
                m_valid = 1;
            end
        end else if (m_valid && pc_load) begin
            case (pc_sel)
                2'd0:    t = m_pc + 64'd4;
                2'd1:    t = m_pc + K * 64'd4;
                2'd2:    t = reg_data;
                default: t = m_pc;
            endcase
            m_valid = 0;
`ifdef IFU_ALIGN_CHECK_EN
            if (t % 64'd4 != 64'd0) m_fault = 1;
            else m_pc = t;
`else
            m_pc = t - (t % 64'd4);
`endif
        end
    endtask

    task automatic check_all();
        chk("pc",          pc,          m_pc);
        chk("pc_plus4",    pc_plus4,    m_pc + 64'd4);
        chk("imem_addr",   imem_addr,   m_pc);
        chk("imem_req",    64'(imem_req),    64'(!m_valid && !m_fault));
        chk("instr_valid", 64'(instr_valid), 64'(m_valid));
        chk("instruction", 64'(instruction), 64'(m_instr));
        chk("fetch_fault", 64'(fetch_fault), 64'(m_fault));
    endtask

    // Called at a negedge: drive, take one posedge, check at following negedge
    task automatic step(input logic rdy, input logic [31:0] rd, input logic ld,
                        input logic [1:0] sel, input logic [63:0] kv, input logic [63:0] rg);
        imem_ready = rdy;
        imem_rdata = rd;
        pc_load    = ld;
        pc_sel     = sel;
        K          = kv;
        reg_data   = rg;
        @(posedge clock);
        model_update();
        @(negedge clock);
        check_all();
    endtask

    initial begin
        reset = 1'b1;
        pc_load = 0; pc_sel = 0; K = 0; reg_data = 0; imem_ready = 0; imem_rdata = 0;
        model_reset();
        repeat (2) @(negedge clock);
        check_all();
        reset = 1'b0;

        // 1: first fetch and sequential advance
        chk("t1_addr", imem_addr, 64'h0);
        step(1, 32'h8B020020, 0, 2'b00, 0, 0);
        chk("t1_instr", 64'(instruction), 64'h8B020020);
        chk("t1_valid", 64'(instr_valid), 64'd1);
        step(0, 0, 1, 2'b00, 0, 0);
        chk("t1_pc", pc, 64'h4);
        chk("t1_req", 64'(imem_req), 64'd1);

        // 2: relative branch backwards, then register branch
        step(1, $urandom, 0, 2'b00, 0, 0);
        step(0, 0, 1, 2'b10, 0, 64'h100);
        step(1, $urandom, 0, 2'b00, 0, 0);
        step(0, 0, 1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        chk("t2_bra", pc, 64'hF8);
        step(1, $urandom, 0, 2'b00, 0, 0);
        step(0, 0, 1, 2'b10, 0, 64'h2000);
        chk("t2_br", pc, 64'h2000);

        // 3: memory stall with stray pc_load pulses
        for (int i = 0; i < 5; i++) begin
            step(0, $urandom, 1'(i), 2'b10, 0, 64'h4000);
            chk("t3_addr", imem_addr, 64'h2000);
        end

        // 4: PC wrap-around at top of address space
        step(1, $urandom, 0, 2'b00, 0, 0);
        step(0, 0, 1, 2'b10, 0, 64'hFFFF_FFFF_FFFF_FFFC);
        step(1, $urandom, 0, 2'b00, 0, 0);
        chk("t4_plus4", pc_plus4, 64'h0);
        step(0, 0, 1, 2'b00, 0, 0);
        chk("t4_wrap", pc, 64'h0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            kk  = int'($urandom_range(0, 2000)) - 1000;
            rgd = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) rgd[1:0] = 2'b00;
            step(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 2) != 0),
                 2'($urandom_range(0, 3)), {{32{kk[31]}}, kk}, rgd);
        end

        // 5: asynchronous reset while stalled in fetch, and while executing
        reset = 1'b1;
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        step(1, $urandom, 0, 2'b00, 0, 0);
        step(0, 0, 1, 2'b10, 0, 64'h40);
        step(0, $urandom, 0, 2'b00, 0, 0);
        #2 reset = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("t5_pc_fetch", pc, c_reset_vector);
        @(negedge clock);
        reset = 1'b0;
        step(1, 32'hCAFE_F00D, 0, 2'b00, 0, 0);
        step(0, 0, 0, 2'b00, 0, 0);
        #2 reset = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("t5_instr_exec", 64'(instruction), 64'(c_instr_reset));
        @(negedge clock);
        reset = 1'b0;

        // 6: misaligned register target
        step(1, $urandom, 0, 2'b00, 0, 0);
        step(0, 0, 1, 2'b10, 0, 64'h2002);
`ifdef IFU_ALIGN_CHECK_EN
        chk("t6_fault", 64'(fetch_fault), 64'd1);
        chk("t6_req", 64'(imem_req), 64'd0);
        chk("t6_pc", pc, c_reset_vector);
        for (int i = 0; i < 3; i++) step(1, $urandom, 1, 2'b00, 0, 0);
        chk("t6_sticky", 64'(fetch_fault), 64'd1);
`else
        chk("t6_pc", pc, 64'h2000);
        chk("t6_fault", 64'(fetch_fault), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
